// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types and constants for the sequential divider
//
// Purpose: FSM state encoding, default operand width and counter sizing
// used by divider and divider_addsub.
// Ports: none (package).
package divider_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    SIGN = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam int WIDTH_DEFAULT = 32;

  // Iteration counter must count 0..w-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/divider_addsub.sv
// rtl/divider_addsub.sv - add/subtract unit for the divider datapath
//
// Purpose: sum = a + b when sub=0, sum = a - b when sub=1 (two's complement,
// b inverted by sub and sub used as carry-in).
// Ports:
//   a   in  W  first operand
//   b   in  W  second operand
//   sub in  1  1 = subtract b, 0 = add b
//   sum out W  result, modulo 2^W
module divider_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  logic [W-1:0] b_eff;

  assign b_eff = b ^ {W{sub}};
  assign sum   = a + b_eff + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - sequential non-restoring integer divider, one quotient bit per clock
//
// Purpose: divides X by Y with a start/done handshake. Signed two's-complement
// semantics when DIVIDER_SIGNED_EN is defined, unsigned otherwise.
// Ports:
//   clk       in  1      rising-edge clock
//   rst       in  1      asynchronous active-high reset
//   start     in  1      request, sampled only in IDLE
//   X         in  WIDTH  dividend, captured on the start edge
//   Y         in  WIDTH  divisor, captured on the start edge
//   quotient  out WIDTH  quotient, truncated toward zero
//   remainder out WIDTH  remainder, sign of dividend
//   done      out 1      one-cycle completion pulse
//   busy      out 1      high in every state except IDLE
//   div_zero  out 1      last operation had Y == 0
//   overflow  out 1      last operation was MIN / -1 (signed build only)
// Configuration macro: DIVIDER_SIGNED_EN
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_zero,
  output logic             overflow
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t state, next_state;

  logic [WIDTH-1:0] x_reg, y_reg;
  logic [WIDTH-1:0] d_reg;          // divisor magnitude
  logic [WIDTH-1:0] q_reg;          // dividend magnitude shifting into quotient
  logic [WIDTH:0]   a_reg;          // signed partial remainder
  logic [CW-1:0]    cnt;

`ifdef DIVIDER_SIGNED_EN
  logic sx, sy;
`endif

  logic [WIDTH:0] add0_a, add0_b, add0_sum;
  logic [WIDTH:0] add1_a, add1_b, add1_sum;
  logic           add0_sub, add1_sub;
  logic           unused_ok;

  // add0 carries the iteration, the final correction and the quotient /
  // divisor negations; add1 handles the dividend / remainder negation that
  // is needed in the same cycle.
  divider_addsub #(.W(WIDTH + 1)) u_add0 (
    .a   (add0_a),
    .b   (add0_b),
    .sub (add0_sub),
    .sum (add0_sum)
  );

  divider_addsub #(.W(WIDTH + 1)) u_add1 (
    .a   (add1_a),
    .b   (add1_b),
    .sub (add1_sub),
    .sum (add1_sum)
  );

  assign unused_ok = &{1'b0, add1_sum};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Divide-by-zero skips ITER/FIX but still passes through SIGN, where the
  // result registers are written, so done follows one cycle later.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = LOAD;
      LOAD: next_state = (y_reg == '0) ? SIGN : ITER;
      ITER: if (cnt == CNT_LAST) next_state = FIX;
      FIX:  next_state = SIGN;
      SIGN: next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    add0_a   = a_reg;
    add0_b   = {1'b0, d_reg};
    add0_sub = 1'b0;
    add1_a   = '0;
    add1_b   = '0;
    add1_sub = 1'b1;
    case (state)
      LOAD: begin
        add0_a   = '0;
        add0_b   = {1'b0, y_reg};
        add0_sub = 1'b1;
        add1_b   = {1'b0, x_reg};
      end
      ITER: begin
        // {A,Q} shifted left; subtract D while A is non-negative.
        add0_a   = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        add0_sub = ~a_reg[WIDTH];
      end
      SIGN: begin
        add0_a   = '0;
        add0_b   = {1'b0, q_reg};
        add0_sub = 1'b1;
        add1_b   = a_reg;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg     <= '0;
      y_reg     <= '0;
      d_reg     <= '0;
      q_reg     <= '0;
      a_reg     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      sx        <= 1'b0;
      sy        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_reg <= X;
            y_reg <= Y;
          end
        end
        LOAD: begin
          cnt      <= '0;
          a_reg    <= '0;
          div_zero <= (y_reg == '0);
          overflow <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
          // |MIN| = 2^(WIDTH-1) still fits as an unsigned magnitude.
          sx    <= x_reg[WIDTH-1];
          sy    <= y_reg[WIDTH-1];
          d_reg <= y_reg[WIDTH-1] ? add0_sum[WIDTH-1:0] : y_reg;
          q_reg <= x_reg[WIDTH-1] ? add1_sum[WIDTH-1:0] : x_reg;
`else
          d_reg <= y_reg;
          q_reg <= x_reg;
`endif
        end
        ITER: begin
          a_reg <= add0_sum;
          q_reg <= {q_reg[WIDTH-2:0], ~add0_sum[WIDTH]};
          cnt   <= cnt + CW'(1);
        end
        FIX: begin
          if (a_reg[WIDTH]) a_reg <= add0_sum;
        end
        SIGN: begin
          if (div_zero) begin
            quotient  <= '1;
            remainder <= x_reg;
          end else begin
`ifdef DIVIDER_SIGNED_EN
            // MIN / -1 needs no special casing: magnitude 2^(WIDTH-1) with
            // equal signs already yields quotient MIN and remainder 0.
            quotient  <= (sx ^ sy) ? add0_sum[WIDTH-1:0] : q_reg;
            remainder <= sx ? add1_sum[WIDTH-1:0] : a_reg[WIDTH-1:0];
            overflow  <= (x_reg == {1'b1, {(WIDTH-1){1'b0}}}) && (y_reg == '1);
`else
            quotient  <= q_reg;
            remainder <= a_reg[WIDTH-1:0];
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - scoreboard testbench for divider
module tb_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] X;
  logic [31:0] Y;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;
  logic        busy;
  logic        div_zero;
  logic        overflow;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic        ov;
    int          lat;
    int          start_edge;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   cyc;

  divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .X         (X),
    .Y         (Y),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .busy      (busy),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 at edge %0d expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
          chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
          chk("latency", 32'(cyc - e.start_edge), 32'(e.lat));
        end
      end
    end
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input logic eov, input int elat,
                        input int glitch);
    exp_t e;
    int   busy_low;
    bit   seen;
    @(posedge clk);
    #1;
    e.q = eq; e.r = er; e.dz = edz; e.ov = eov; e.lat = elat;
    e.start_edge = cyc + 1;
    exp_q.push_back(e);
    X = x; Y = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    X = 32'hDEADBEEF; Y = 32'd1;
    busy_low = 0;
    seen = 0;
    for (int i = 1; i < 60; i++) begin
      if (glitch != 0 && i == glitch) begin
        start = 1'b1; X = 32'd50; Y = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (!busy) busy_low++;
    end
    start = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout: got no done within 60 cycles expected done for %h/%h", x, y);
      exp_q.delete();
    end
    chk("busy_low_cycles", 32'(busy_low), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0;
    X = '0;
    Y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_div_zero", {31'd0, div_zero}, 32'd0);
    chk("reset_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;

    fork
      monitor();
    join_none

    run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 35, 0);
`ifdef DIVIDER_SIGNED_EN
    run_op(32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0, 35, 0);
    run_op(32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, 1'b0, 35, 0);
    run_op(32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0, 1'b0, 35, 0);
    run_op(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b1, 35, 0);
`else
    run_op(32'hFFFFFF9C, 32'd7, 32'h24924916, 32'd2, 1'b0, 1'b0, 35, 0);
    run_op(32'd100, 32'hFFFFFFF9, 32'd0, 32'd100, 1'b0, 1'b0, 35, 0);
    run_op(32'hFFFFFF9C, 32'hFFFFFFF9, 32'd0, 32'hFFFFFF9C, 1'b0, 1'b0, 35, 0);
    run_op(32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 1'b0, 35, 0);
`endif
    run_op(32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 1'b0, 35, 0);
    run_op(32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b0, 2, 0);
    run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 35, 10);

    // Abort an operation with reset: outputs clear at once, no done follows.
    @(posedge clk);
    #1;
    X = 32'd100; Y = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_div_zero", {31'd0, div_zero}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    run_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 35, 0);

    repeat (5) @(posedge clk);
    chk("pending_results", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
